// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational RV32I ALU among NUM_REQ requesters, with a
// one-entry response slot per requester. Define ALU_ARB_STATS_EN to add grant/starve counters.
module alu_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int IDX_W        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op1,
  input  logic [32*NUM_REQ-1:0]  req_op2,
  input  logic [32*NUM_REQ-1:0]  req_instr,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [32*NUM_REQ-1:0]  rsp_data,
  output logic [31:0]            alu_op1,
  output logic [31:0]            alu_op2,
  output logic [31:0]            alu_instr,
  input  logic [31:0]            alu_res,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  stat_grants,
  output logic [15:0]            stat_starve
`endif
);

  // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i]; a response
  // transfers where rsp_valid[i] & rsp_ready[i]. Requesters hold operands stable while valid & !ready.

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t          slot_q [NUM_REQ];
  slot_state_t          slot_d [NUM_REQ];
  logic [CNT_W-1:0]     wait_q [NUM_REQ];
  logic [CNT_W-1:0]     wait_d [NUM_REQ];
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   starved;
  logic [2*NUM_REQ-1:0] elig_rot;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_id;
  logic                 grant_any;
  logic                 starve_hit;

  // Eligibility and starvation flags
  always_comb begin
    elig    = '0;
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i]    = req_valid[i] & ((slot_q[i] == SLOT_EMPTY) | rsp_ready[i]);
      starved[i] = (STARVE_LIMIT != 0) && elig[i] && (wait_q[i] >= LIMIT);
    end
  end

  // Winner selection: lowest starved index first, otherwise first eligible from rr_ptr upward.
  always_comb begin
    starve_hit = 1'b0;
    grant_id   = '0;
    elig_rot   = {elig, elig} >> rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (starved[i]) begin
        starve_hit = 1'b1;
        grant_id   = IDX_W'(i);
      end
    end
    if (!starve_hit) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (elig_rot[k]) begin
          grant_id = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        end
      end
    end
    grant_any = rst_n && (|elig);
    grant     = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    rr_ptr_d  = grant_any ? IDX_W'((int'(grant_id) + 1) % NUM_REQ) : rr_ptr_q;
  end

  assign req_ready = grant;
  assign busy      = grant_any;
  assign grant_idx = grant_any ? grant_id : '0;

  // One-hot grant makes an OR-mux sufficient; no grant drives zeros into the ALU.
  always_comb begin
    alu_op1   = '0;
    alu_op2   = '0;
    alu_instr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_op1   = alu_op1   | req_op1[32*i +: 32];
        alu_op2   = alu_op2   | req_op2[32*i +: 32];
        alu_instr = alu_instr | req_instr[32*i +: 32];
      end
    end
  end

  // Response slot FSM and wait counters
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_EMPTY: if (grant[i]) slot_d[i] = SLOT_FULL;
        SLOT_FULL:  if (rsp_ready[i] && !grant[i]) slot_d[i] = SLOT_EMPTY;
        default:    slot_d[i] = SLOT_EMPTY;
      endcase

      wait_d[i] = wait_q[i];
      if (!req_valid[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] < LIMIT) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (slot_q[i] == SLOT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      rsp_data <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= SLOT_EMPTY;
        wait_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
        wait_q[i] <= wait_d[i];
        if (grant[i]) begin
          rsp_data[32*i +: 32] <= alu_res;
        end
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_starve <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (stat_grants[16*i +: 16] != 16'hFFFF)) begin
          stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
        end
      end
      if (grant_any && starve_hit && (stat_starve != 16'hFFFF)) begin
        stat_starve <= stat_starve + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (3 requesters, starve limit 2): vector table, corner-case sequences and a
// response scoreboard fed by a reference RV32I ALU model.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int NREQ  = 3;
  localparam int LIMIT = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_op1;
  logic [32*NREQ-1:0]  req_op2;
  logic [32*NREQ-1:0]  req_instr;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [32*NREQ-1:0]  rsp_data;
  logic [31:0]         alu_op1;
  logic [31:0]         alu_op2;
  logic [31:0]         alu_instr;
  logic [31:0]         alu_res;
  logic [1:0]          grant_idx;
  logic                busy;
`ifdef ALU_ARB_STATS_EN
  logic [16*NREQ-1:0]  stat_grants;
  logic [15:0]         stat_starve;
`endif

  logic [31:0] op1 [NREQ];
  logic [31:0] op2 [NREQ];
  logic [31:0] ins [NREQ];

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {requester index, expected result}.
  logic [33:0] exp_q[$];

  typedef struct {
    int          idx;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [10];

  assign req_op1   = {op1[2], op1[1], op1[0]};
  assign req_op2   = {op2[2], op2[1], op2[0]};
  assign req_instr = {ins[2], ins[1], ins[0]};

  function automatic logic [31:0] alu_model(input logic [31:0] instr, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;
    opc = instr[6:0];
    f3  = instr[14:12];
    alt = instr[30] && ((opc == 7'h33) || (f3 == 3'd5));
    case (f3)
      3'd0:    return alt ? (a - b) : (a + b);
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res = alu_model(alu_instr, alu_op1, alu_op2);

  alu_arbiter #(
    .NUM_REQ      (NREQ),
    .STARVE_LIMIT (LIMIT),
    .IDX_W        (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_instr (req_instr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_instr (alu_instr),
    .alu_res   (alu_res),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_starve (stat_starve)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b);
    ins[i]       = instr;
    op1[i]       = a;
    op2[i]       = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard
  task automatic sb_pop(input int i, input logic [31:0] data);
    int found;
    found = -1;
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j][33:32] == 2'(i)) found = j;
    end
    if (found < 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected_rsp%0d: got %h expected no response", i, data);
    end else begin
      check($sformatf("sb_rsp%0d", i), 96'(data), 96'(exp_q[found][31:0]));
      exp_q.delete(found);
    end
  endtask

  task automatic sb_monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) sb_pop(i, rsp_data[32*i +: 32]);
        end
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            exp_q.push_back({2'(i), alu_model(ins[i], op1[i], op2[i])});
          end
        end
      end
    end
  endtask

  initial begin
    int g_rr[4];
    int g_st[3];

    vecs[0] = '{0, 32'h40000033, 32'd10,        32'd3,  32'd7};
    vecs[1] = '{1, 32'h00000013, 32'd1,         32'd2,  32'd3};
    vecs[2] = '{2, 32'h00007033, 32'hF0,        32'h3C, 32'h30};
    vecs[3] = '{0, 32'h00006033, 32'hF0,        32'h0F, 32'hFF};
    vecs[4] = '{1, 32'h00004033, 32'hFF,        32'h0F, 32'hF0};
    vecs[5] = '{2, 32'h00002033, 32'hFFFFFFFF,  32'd1,  32'd1};
    vecs[6] = '{0, 32'h00003033, 32'hFFFFFFFF,  32'd1,  32'd0};
    vecs[7] = '{1, 32'h00001033, 32'd1,         32'd4,  32'h10};
    vecs[8] = '{2, 32'h40005033, 32'h80000000,  32'd4,  32'hF8000000};
    vecs[9] = '{0, 32'h00005033, 32'h80000000,  32'd4,  32'h08000000};
    g_rr = '{0, 1, 0, 1};
    g_st = '{2, 0, 2};

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      op1[i] = '0;
      op2[i] = '0;
      ins[i] = '0;
    end
    fork
      sb_monitor();
    join_none

    // Reset state; requests must not be accepted while rst_n is low.
    repeat (2) tick();
    req_valid = '1;
    #1;
    check("reset_req_ready", 96'(req_ready), 96'd0);
    check("reset_busy",      96'(busy),      96'd0);
    check("reset_rsp_valid", 96'(rsp_valid), 96'd0);
    check("reset_rsp_data",  96'(rsp_data),  96'd0);
`ifdef ALU_ARB_STATS_EN
    check("reset_stat_grants", 96'(stat_grants), 96'd0);
    check("reset_stat_starve", 96'(stat_starve), 96'd0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Single ADD
    drive(0, 32'h00000033, 32'd5, 32'd7);
    rsp_ready = '1;
    #1;
    check("add_req_ready", 96'(req_ready), 96'b001);
    check("add_grant_idx", 96'(grant_idx), 96'd0);
    check("add_busy",      96'(busy),      96'd1);
    check("add_alu_op1",   96'(alu_op1),   96'd5);
    tick();
    req_valid = '0;
    #1;
    check("add_rsp_valid", 96'(rsp_valid),      96'b001);
    check("add_rsp_data",  96'(rsp_data[31:0]), 96'd12);
    check("add_idle_busy", 96'(busy),           96'd0);
    check("add_idle_alu",  {alu_op1, alu_op2, alu_instr}, 96'd0);
    tick();

    // Vector table: one requester per cycle across the ALU operations
    for (int v = 0; v < 10; v++) begin
      req_valid = '0;
      rsp_ready = '1;
      drive(vecs[v].idx, vecs[v].instr, vecs[v].a, vecs[v].b);
      #1;
      check($sformatf("vec%0d_ready", v), 96'(req_ready), 96'(NREQ'(1) << vecs[v].idx));
      check($sformatf("vec%0d_idx", v),   96'(grant_idx), 96'(vecs[v].idx));
      check($sformatf("vec%0d_instr", v), 96'(alu_instr), 96'(vecs[v].instr));
      check($sformatf("vec%0d_op2", v),   96'(alu_op2),   96'(vecs[v].b));
      tick();
      req_valid = '0;
      #1;
      check($sformatf("vec%0d_rsp_valid", v), 96'(rsp_valid[vecs[v].idx]), 96'd1);
      check($sformatf("vec%0d_rsp_data", v),  96'(rsp_data[32*vecs[v].idx +: 32]), 96'(vecs[v].res));
      tick();
    end

    // Reset the cycle after a grant: in-flight result dropped, rr_ptr back to 0
    drive(0, 32'h00000033, 32'd5, 32'd7);
    rsp_ready = '0;
    #1;
    check("midop_ready", 96'(req_ready), 96'b001);
    tick();
    req_valid = '0;
    drive(1, 32'h00000033, 32'd1, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_full",      96'(rsp_valid[0]), 96'd1);
    check("midop_rst_ready", 96'(req_ready),    96'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    #1;
    check("midop_rsp_valid", 96'(rsp_valid), 96'd0);
    check("midop_rsp_data",  96'(rsp_data),  96'd0);
`ifdef ALU_ARB_STATS_EN
    check("midop_stat_grants", 96'(stat_grants), 96'd0);
    check("midop_stat_starve", 96'(stat_starve), 96'd0);
`endif

    // Contention round-robin
    drive(0, 32'h40000033, 32'd10, 32'd3);
    drive(1, 32'h00000013, 32'd1,  32'd2);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr%0d_idx", c),   96'(grant_idx), 96'(g_rr[c]));
      check($sformatf("rr%0d_ready", c), 96'(req_ready), 96'(NREQ'(1) << g_rr[c]));
      tick();
    end
    req_valid = '0;
    #1;
    check("rr_data0", 96'(rsp_data[31:0]),  96'd7);
    check("rr_data1", 96'(rsp_data[63:32]), 96'd3);
    tick();
    tick();

    // Backpressure on slot 0 while requester 1 keeps being served
    rsp_ready = 3'b110;
    drive(0, 32'h00000033, 32'd100, 32'd23);
    #1;
    check("bp_first_ready", 96'(req_ready), 96'b001);
    tick();
    drive(0, 32'h00000033, 32'd1, 32'd1);
    drive(1, 32'h00000013, 32'd4, 32'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_ready", c), 96'(req_ready),      96'b010);
      check($sformatf("bp%0d_full", c),  96'(rsp_valid[0]),   96'd1);
      check($sformatf("bp%0d_hold", c),  96'(rsp_data[31:0]), 96'd123);
      tick();
    end
    rsp_ready = '1;
    #1;
    check("bp_release_ready", 96'(req_ready), 96'b001);
    tick();
`ifdef ALU_ARB_STATS_EN
    check("bp_stat_starve", 96'(stat_starve), 96'd1);
`endif

    // Drain and grant in the same cycle keeps the slot full with new data
    req_valid = '0;
    drive(0, 32'h00007033, 32'hF0, 32'h3C);
    #1;
    check("dg_pre_full",  96'(rsp_valid[0]),   96'd1);
    check("dg_pre_data",  96'(rsp_data[31:0]), 96'd2);
    check("dg_ready",     96'(req_ready),      96'b001);
    tick();
    req_valid = '0;
    #1;
    check("dg_post_full", 96'(rsp_valid[0]),   96'd1);
    check("dg_post_data", 96'(rsp_data[31:0]), 96'h30);
    tick();
    tick();

    // Starvation override after requester 1 is blocked by its own full slot
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready = 3'b101;
    drive(1, 32'h00000033, 32'd20, 32'd22);
    #1;
    check("st_first_ready", 96'(req_ready), 96'b010);
    tick();
    drive(0, 32'h00000013, 32'd1, 32'd1);
    drive(1, 32'h00000033, 32'd3, 32'd3);
    drive(2, 32'h00000013, 32'd2, 32'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("st%0d_idx", c),     96'(grant_idx),    96'(g_st[c]));
      check($sformatf("st%0d_blocked", c), 96'(req_ready[1]), 96'd0);
      tick();
    end
    rsp_ready = '1;
    #1;
    check("st_override_idx",   96'(grant_idx), 96'd1);
    check("st_override_ready", 96'(req_ready), 96'b010);
    tick();
    req_valid = '0;
    #1;
    check("st_data1", 96'(rsp_data[63:32]), 96'd6);
`ifdef ALU_ARB_STATS_EN
    check("st_stat_starve", 96'(stat_starve), 96'd1);
    check("st_stat_grants", 96'(stat_grants), 96'({16'd2, 16'd2, 16'd1}));
`endif

    // Idle: everything drains, ALU inputs return to zero
    tick();
    tick();
    #1;
    check("idle_alu",       {alu_op1, alu_op2, alu_instr}, 96'd0);
    check("idle_grant_idx", 96'(grant_idx), 96'd0);
    check("idle_busy",      96'(busy),      96'd0);
    check("idle_rsp_valid", 96'(rsp_valid), 96'd0);
    check("sb_empty",       96'(exp_q.size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
